// File: rtl/core_pkg.sv
// Shared types and instruction-class encodings for the core control sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } ctrl_state_t;

  localparam logic [1:0] CLS_ARITH0 = 2'b00;
  localparam logic [1:0] CLS_ARITH1 = 2'b01;
  localparam logic [1:0] CLS_MEM    = 2'b10;
  localparam logic [1:0] CLS_BR     = 2'b11;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-wait cycle counter: loads 1 on entry to a wait state, counts up while
// waiting and flags expiry once MEM_TIMEOUT cycles have been spent there.
module ctrl_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: the first cycle in the state reads as 1, saturating at TMAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = TW'(1);
    end else if (enable_i && (cnt_q < TMAX)) begin
      cnt_d = cnt_q + TW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {TW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= TMAX);

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback with
// per-wait timeout into ERR and a wrapping retired-instruction counter.
module core_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic [1:0]       inst_class,
  input  logic             inst_sub,
  input  logic             inst_halt,
  input  logic             cond_true,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             rf_we,
  output logic             alu_src_imm,
  output logic             wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             busy,
  output logic             halted,
  output logic             err
);

  import core_pkg::*;

  ctrl_state_t      state_q;
  ctrl_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_expired;

  ctrl_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clr),
    .enable_i  (tmr_en),
    .expired_o (tmr_expired)
  );

  // Restart the timer on any transition into a wait state; it only matters there.
  assign tmr_clr = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));
  assign tmr_en  = (state_q == ST_FETCH) || (state_q == ST_MEM);

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    rf_we       = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;
    retire      = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        ir_we    = imem_ack;
        // Ack on the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        busy = 1'b1;
        if (inst_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy = 1'b1;
        case (inst_class)
          CLS_ARITH0, CLS_ARITH1: begin
            alu_src_imm = inst_sub;
            state_d     = ST_WB;
          end
          CLS_MEM: begin
            state_d = ST_MEM;
          end
          CLS_BR: begin
            pc_we   = 1'b1;
            pc_src  = inst_sub | cond_true;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
            state_d = ST_ERR;
          end
        endcase
      end
      ST_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = inst_sub;
        if (dmem_ack) begin
          if (inst_sub) begin
            pc_we   = 1'b1;
            pc_src  = 1'b0;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        busy    = 1'b1;
        rf_we   = 1'b1;
        wb_sel  = (inst_class == CLS_MEM);
        pc_we   = 1'b1;
        pc_src  = 1'b0;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign cnt_d = retire ? (cnt_q + CNT_W'(1)) : cnt_q;

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;

endmodule
